// File: rtl/imm_pkg.sv
// Shared types and constants for the pipelined immediate generator.
package imm_pkg;

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_e;

  function automatic logic src_is_legal(input logic [2:0] src);
    return src <= 3'(IMM_J);
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Two-entry valid/ready register slice (output register plus optional skid entry).
module imm_skid_buf #(
  parameter int unsigned WIDTH   = 33,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (SKID_EN) begin : g_skid
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    // Registered ready: the skid entry absorbs the item accepted while output stalls.
    assign in_ready = !skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid  <= 1'b0;
        out_data   <= '0;
        skid_valid <= 1'b0;
        skid_data  <= '0;
      end else if (!out_valid || out_ready) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_data   <= skid_data;
          skid_valid <= 1'b0;
        end else begin
          out_valid <= in_valid;
          if (in_valid) out_data <= in_data;
        end
      end else if (in_valid && !skid_valid) begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
      end
    end
  end else begin : g_pass
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid <= 1'b0;
        out_data  <= '0;
      end else if (in_ready) begin
        out_valid <= in_valid;
        if (in_valid) out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate decode for RV32I I/S/B/U/J formats, sign-extended to XLEN, behind a skid slice.
// Define IMM_GEN_ERR_EN to add illegal_o and the saturating illegal_cnt_o counter.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [2:0]         imm_src,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef IMM_GEN_ERR_EN
  output logic               illegal_o,
  output logic [7:0]         illegal_cnt_o,
`endif
  output logic [XLEN-1:0]    ImmOp
);

  logic [INSTR_W-1:0] raw;
  logic [XLEN-1:0]    imm;
  logic               unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    raw = '0;
    case (imm_src_e'(imm_src))
      IMM_I:   raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   raw = {instr[31:12], 12'b0};
      IMM_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: raw = '0;
    endcase
  end

  // Bit 31 of every format is instr[31], so widening is a plain signed extension.
  assign imm = XLEN'(signed'(raw));

`ifdef IMM_GEN_ERR_EN
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic            illegal;
  } payload_t;

  payload_t in_pl;
  payload_t out_pl;
  logic     drain;

  assign in_pl = '{imm: imm, illegal: !src_is_legal(imm_src)};

  imm_skid_buf #(
    .WIDTH   ($bits(payload_t)),
    .SKID_EN (SKID_EN)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_pl)
  );

  assign ImmOp     = out_pl.imm;
  assign illegal_o = out_valid && out_pl.illegal;
  assign drain     = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt_o <= '0;
    end else if (drain && out_pl.illegal && (illegal_cnt_o != 8'hFF)) begin
      illegal_cnt_o <= illegal_cnt_o + 8'd1;
    end
  end
`else
  imm_skid_buf #(
    .WIDTH   (XLEN),
    .SKID_EN (SKID_EN)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (ImmOp)
  );
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe (XLEN 32 and 64 instances) against a queue-based reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [2:0]  imm_src = '0;
  logic        out_ready = 1'b0;
  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] imm32;
  logic [63:0] imm64;
`ifdef IMM_GEN_ERR_EN
  logic        ill32, ill64;
  logic [7:0]  cnt32, cnt64;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] imm;
    bit          ill;
  } ent_t;

  ent_t q[$];
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SKID_EN(1'b1)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .imm_src(imm_src), .out_valid(out_valid32), .out_ready(out_ready),
`ifdef IMM_GEN_ERR_EN
    .illegal_o(ill32), .illegal_cnt_o(cnt32),
`endif
    .ImmOp(imm32)
  );

  imm_gen_pipe #(.XLEN(64), .SKID_EN(1'b1)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .imm_src(imm_src), .out_valid(out_valid64), .out_ready(out_ready),
`ifdef IMM_GEN_ERR_EN
    .illegal_o(ill64), .illegal_cnt_o(cnt64),
`endif
    .ImmOp(imm64)
  );

  // Immediate value from the format rules, using signed arithmetic on the word.
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s);
    longint sx;
    sx = longint'($signed(i));
    case (s)
      3'd0: return 64'(sx >>> 20);
      3'd1: return 64'((sx >>> 25) * 32 + longint'(i[11:7]));
      3'd2: return 64'((sx >>> 31) * 4096 + longint'(i[7]) * 2048
                       + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2);
      3'd3: return 64'((sx >>> 12) * 4096);
      3'd4: return 64'((sx >>> 31) * 1048576 + longint'(i[19:12]) * 4096
                       + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2);
      default: return 64'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input bit v, input logic [31:0] ins, input logic [2:0] src, input bit ordy);
    bit exp_rdy, exp_ov, acc, drn;
    in_valid  = v;
    instr     = ins;
    imm_src   = src;
    out_ready = ordy;
    #1;
    exp_rdy = (q.size() < 2);
    exp_ov  = (q.size() > 0);
    chk("in_ready32", 64'(in_ready32), 64'(exp_rdy));
    chk("in_ready64", 64'(in_ready64), 64'(exp_rdy));
    chk("out_valid32", 64'(out_valid32), 64'(exp_ov));
    chk("out_valid64", 64'(out_valid64), 64'(exp_ov));
    if (exp_ov) begin
      chk("ImmOp32", 64'(imm32), 64'(q[0].imm[31:0]));
      chk("ImmOp64", imm64, q[0].imm);
`ifdef IMM_GEN_ERR_EN
      chk("illegal_o", 64'(ill32), 64'(q[0].ill));
`endif
    end
`ifdef IMM_GEN_ERR_EN
    chk("illegal_cnt", 64'(cnt32), 64'(exp_cnt));
`endif
    acc = v && exp_rdy;
    drn = exp_ov && ordy;
    @(posedge clk);
    #1;
    if (drn) begin
      if (q[0].ill && exp_cnt < 255) exp_cnt++;
      void'(q.pop_front());
    end
    if (acc) q.push_back('{imm: ref_imm(ins, src), ill: (src > 3'd4)});
  endtask

  initial begin
    // Reset state while held in reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid32), 64'd0);
    chk("rst_ImmOp", 64'(imm32), 64'd0);
    chk("rst_in_ready", 64'(in_ready32), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Spec vectors back-to-back with no bubbles
    cycle(1, 32'hFFF00093, 3'd0, 1);
    chk("vec_I", 64'(imm32), 64'hFFFFFFFF);
    cycle(1, 32'hFE112E23, 3'd1, 1);
    chk("vec_S", 64'(imm32), 64'hFFFFFFFC);
    cycle(1, 32'hFE000EE3, 3'd2, 1);
    chk("vec_B", 64'(imm32), 64'hFFFFFFFC);
    cycle(1, 32'h123450B7, 3'd3, 1);
    chk("vec_U", 64'(imm32), 64'h12345000);
    chk("vec_U64", imm64, 64'h0000000012345000);
    cycle(1, 32'hFFDFF06F, 3'd4, 1);
    chk("vec_J", 64'(imm32), 64'hFFFFFFFC);
    cycle(1, 32'h800000B7, 3'd3, 1);
    chk("vec_U64_neg", imm64, 64'hFFFFFFFF80000000);
    cycle(0, 32'h0, 3'd0, 1);

    // Backpressure: third item must be refused, then drain in order
    cycle(1, 32'h00100093, 3'd0, 0);
    cycle(1, 32'h00200093, 3'd0, 0);
    chk("bp_in_ready_low", 64'(in_ready32), 64'd0);
    cycle(1, 32'h00300093, 3'd0, 0);
    cycle(0, 32'h0, 3'd0, 0);
    cycle(0, 32'h0, 3'd0, 1);
    chk("bp_second_out", 64'(imm32), 64'd2);
    cycle(0, 32'h0, 3'd0, 1);
    cycle(0, 32'h0, 3'd0, 1);

    // Illegal source emits zero
    cycle(1, 32'hFFFFFFFF, 3'd6, 1);
    chk("illegal_zero", 64'(imm32), 64'd0);
    cycle(1, 32'hFFFFFFFF, 3'd5, 0);
    cycle(1, 32'h12345678, 3'd7, 1);
    cycle(0, 32'h0, 3'd0, 1);

    // Randomized traffic with random backpressure
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom % 4) != 0, $urandom, 3'($urandom_range(0, 7)), ($urandom % 3) != 0);
    end
    for (int n = 0; n < 3; n++) cycle(0, 32'h0, 3'd0, 1);

`ifdef IMM_GEN_ERR_EN
    for (int n = 0; n < 300; n++) cycle(1, $urandom, 3'd6, 1);
    for (int n = 0; n < 3; n++) cycle(0, 32'h0, 3'd0, 1);
    chk("cnt_saturated", 64'(cnt32), 64'd255);
`endif

    // Reset while two items are stalled
    cycle(1, 32'hFFF00093, 3'd0, 0);
    cycle(1, 32'hFFE00093, 3'd0, 0);
    chk("stall_in_ready", 64'(in_ready32), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid32), 64'd0);
    chk("arst_ImmOp", 64'(imm32), 64'd0);
    chk("arst_ImmOp64", imm64, 64'd0);
    chk("arst_in_ready", 64'(in_ready32), 64'd1);
    q.delete();
    exp_cnt = 0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 3; n++) cycle(0, 32'h0, 3'd0, 1);
    cycle(1, 32'h00000013, 3'd0, 1);
    cycle(0, 32'h0, 3'd0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
